// File: rtl/cnn_layer_pkg.sv
// Shared types and helpers for the CNN layer datapath blocks.
// Holds the output-size function, the bfloat16 width and the writeback FSM state type.
package cnn_layer_pkg;

    localparam int BW_BF16 = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    // Output feature-map height/width for a square convolution.
    function automatic int oh_f(input int ih, input int wh, input int p, input int s);
        return (ih - wh + 2 * p) / s + 1;
    endfunction

endpackage

// File: rtl/ofmap_coord_cnt.sv
// Cascaded col -> row -> k counters with an incrementally tracked linear address.
// 'last' flags the final element of the layer (k=K-1, row=col=OH-1).
module ofmap_coord_cnt #(
    parameter int K  = 4,
    parameter int OH = 8,
    parameter int KW = 2,
    parameter int CW = 3,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [KW-1:0] k,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic col_wrap;
    logic row_wrap;
    logic k_wrap;

    assign col_wrap = (col == CW'(OH - 1));
    assign row_wrap = (row == CW'(OH - 1));
    assign k_wrap   = (k == KW'(K - 1));
    assign last     = k_wrap && row_wrap && col_wrap;

    // Address rides along with the counters, so no k*NPIX + row*OH multiply is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k    <= '0;
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (clr) begin
            k    <= '0;
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (adv) begin
            addr <= addr + AW'(1);
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row <= '0;
                    k   <= k_wrap ? '0 : k + KW'(1);
                end else begin
                    row <= row + CW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ofmap_writeback_sched.sv
// Tags the filter-major ofmap stream with (k,row,col,addr) and issues buffer writes.
// Define OFMAP_RELU_EN to clamp negative elements (sign bit set) to +0 on the write path.
module ofmap_writeback_sched
    import cnn_layer_pkg::*;
#(
    parameter  int K    = 4,
    parameter  int IH   = 8,
    parameter  int WH   = 3,
    parameter  int P    = 1,
    parameter  int S    = 1,
    parameter  int BW   = BW_BF16,
    localparam int OH   = oh_f(IH, WH, P, S),
    localparam int NPIX = OH * OH,
    localparam int AW   = (K * NPIX > 1) ? $clog2(K * NPIX) : 1,
    localparam int KW   = (K > 1) ? $clog2(K) : 1,
    localparam int CW   = (OH > 1) ? $clog2(OH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [BW-1:0] wr_data,
    output logic [KW-1:0] wr_k,
    output logic [CW-1:0] wr_row,
    output logic [CW-1:0] wr_col
);

    wb_state_t     state;
    wb_state_t     state_nxt;
    logic          accept;
    logic [KW-1:0] cur_k;
    logic [CW-1:0] cur_row;
    logic [CW-1:0] cur_col;
    logic [AW-1:0] cur_addr;
    logic          cur_last;
    logic [BW-1:0] data_fmt;

    assign accept = in_valid && in_ready;

    ofmap_coord_cnt #(
        .K (K),
        .OH(OH),
        .KW(KW),
        .CW(CW),
        .AW(AW)
    ) u_coord (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .adv (accept),
        .k   (cur_k),
        .row (cur_row),
        .col (cur_col),
        .addr(cur_addr),
        .last(cur_last)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && cur_last) state_nxt = DRAIN;
            DRAIN:   if (wr_valid && wr_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        in_ready = (state == RUN) && (!wr_valid || wr_ready);
    end

`ifdef OFMAP_RELU_EN
    assign data_fmt = in_data[BW-1] ? '0 : in_data;
`else
    assign data_fmt = in_data;
`endif

    // NOTE: the payload register is reset as well, because every output must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_k     <= '0;
            wr_row   <= '0;
            wr_col   <= '0;
        end else if (accept) begin
            wr_valid <= 1'b1;
            wr_addr  <= cur_addr;
            wr_data  <= data_fmt;
            wr_k     <= cur_k;
            wr_row   <= cur_row;
            wr_col   <= cur_col;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

endmodule
